// File: rtl/btb_multi_lane.sv
// Multi-lane branch target buffer for the superscalar fetch stage.
// Direct-mapped table looked up for FETCH_WIDTH sequential PCs per cycle,
// trained by the resolve-side update port and invalidated by a sweep FSM.
module btb_multi_lane #(
  parameter int PC_BITS     = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int ENTRIES     = 64,
  parameter int TAG_BITS    = 8,
  localparam int IDX        = $clog2(ENTRIES),
  localparam int LANE_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_valid_i,
  input  logic [PC_BITS-1:0]     lookup_pc_i,
  output logic                   lookup_ready_o,
  output logic                   resp_valid_o,
  output logic [FETCH_WIDTH-1:0] resp_hit_o,
  output logic                   resp_any_taken_o,
  output logic [LANE_W-1:0]      resp_taken_lane_o,
  output logic [PC_BITS-1:0]     resp_target_o,
  output logic                   resp_is_call_o,
  output logic                   resp_backward_o,
  input  logic                   upd_valid_i,
  input  logic [PC_BITS-1:0]     upd_pc_i,
  input  logic [PC_BITS-1:0]     upd_target_i,
  input  logic                   upd_taken_i,
  input  logic                   upd_is_call_i,
  input  logic                   flush_i,
  output logic                   busy_o
);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t state_q, state_d;
  logic [IDX-1:0] sweep_idx_q, sweep_idx_d;

  // Table storage; only the valid bits need clearing, the payload is don't-care when invalid
  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  call_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [PC_BITS-1:0]  target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  // Per-lane lookup view
  logic [PC_BITS-1:0]     lane_pc  [FETCH_WIDTH];
  logic [IDX-1:0]         lane_idx [FETCH_WIDTH];
  logic [PC_BITS-1:0]     lane_tgt [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] lane_hit;
  logic [FETCH_WIDTH-1:0] lane_taken;
  logic [FETCH_WIDTH-1:0] lane_call;
  logic [FETCH_WIDTH-1:0] lane_back;

  // First-taken-lane selection result
  logic                   any_taken_c;
  logic [LANE_W-1:0]      taken_lane_c;
  logic [PC_BITS-1:0]     target_c;
  logic                   call_c;
  logic                   backward_c;

  logic                   lookup_fire;
  logic [IDX-1:0]         upd_idx;
  logic [TAG_BITS-1:0]    upd_tag;
  logic                   upd_hit;
  logic                   upd_en;

  // PC bits below the index and above the tag play no part in the mapping
  logic unused_upd_pc_bits;
  assign unused_upd_pc_bits = ^{upd_pc_i[1:0], upd_pc_i[PC_BITS-1:2+IDX+TAG_BITS]};

  assign lookup_ready_o = (state_q == IDLE) && !flush_i;
  assign busy_o         = (state_q == SWEEP);
  assign lookup_fire    = lookup_valid_i && lookup_ready_o;

  assign upd_idx = upd_pc_i[2 +: IDX];
  assign upd_tag = upd_pc_i[2+IDX +: TAG_BITS];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_en  = upd_valid_i && (state_q == IDLE) && !flush_i && !rst;

  // Lane PCs wrap naturally in PC_BITS arithmetic; each lane reads its own entry
  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
    assign lane_pc[k]    = lookup_pc_i + PC_BITS'(4 * k);
    assign lane_idx[k]   = lane_pc[k][2 +: IDX];
    assign lane_hit[k]   = valid_q[lane_idx[k]] &&
                           (tag_q[lane_idx[k]] == lane_pc[k][2+IDX +: TAG_BITS]);
    assign lane_taken[k] = lane_hit[k] && ctr_q[lane_idx[k]][1];
    assign lane_tgt[k]   = target_q[lane_idx[k]];
    assign lane_call[k]  = call_q[lane_idx[k]];
    assign lane_back[k]  = lane_tgt[k] < lane_pc[k];
  end

  // Sweep state register; reset restarts the invalidation sweep from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SWEEP;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  // Next-state logic: a flush always (re)starts the sweep at entry 0
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d     = SWEEP;
          sweep_idx_d = '0;
        end
      end
      SWEEP: begin
        if (flush_i) begin
          sweep_idx_d = '0;
        end else if (sweep_idx_q == IDX'(ENTRIES - 1)) begin
          state_d     = IDLE;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + IDX'(1);
        end
      end
      default: begin
        state_d     = SWEEP;
        sweep_idx_d = '0;
      end
    endcase
  end

  // Valid bits: the sweep clears one entry per cycle, a taken miss allocates
  always_ff @(posedge clk) begin
    if (state_q == SWEEP) begin
      valid_q[sweep_idx_q] <= 1'b0;
    end else if (upd_en && !upd_hit && upd_taken_i) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Entry payload training: saturating counter on hit, fresh weakly-taken entry on taken miss
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          if (ctr_q[upd_idx] != 2'b11) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
          end
          target_q[upd_idx] <= upd_target_i;
          call_q[upd_idx]   <= upd_is_call_i;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        call_q[upd_idx]   <= upd_is_call_i;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

  // Pick the lowest-numbered taken lane; scanning downward lets lower lanes win
  always_comb begin
    any_taken_c  = 1'b0;
    taken_lane_c = '0;
    target_c     = '0;
    call_c       = 1'b0;
    backward_c   = 1'b0;
    for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
      if (lane_taken[k]) begin
        any_taken_c  = 1'b1;
        taken_lane_c = LANE_W'(k);
        target_c     = lane_tgt[k];
        call_c       = lane_call[k];
        backward_c   = lane_back[k];
      end
    end
  end

  // Response register: reads pre-update table contents, all fields zero when not valid
  always_ff @(posedge clk) begin
    if (rst || !lookup_fire) begin
      resp_valid_o      <= 1'b0;
      resp_hit_o        <= '0;
      resp_any_taken_o  <= 1'b0;
      resp_taken_lane_o <= '0;
      resp_target_o     <= '0;
      resp_is_call_o    <= 1'b0;
      resp_backward_o   <= 1'b0;
    end else begin
      resp_valid_o      <= 1'b1;
      resp_hit_o        <= lane_hit;
      resp_any_taken_o  <= any_taken_c;
      resp_taken_lane_o <= taken_lane_c;
      resp_target_o     <= target_c;
      resp_is_call_o    <= call_c;
      resp_backward_o   <= backward_c;
    end
  end

endmodule

// File: tb/tb_btb_multi_lane.sv
// Self-checking bench for btb_multi_lane: directed scenarios followed by random
// traffic, compared against a table-level reference model through a scoreboard.
module tb_btb_multi_lane;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        lookup_ready_o;
  logic        resp_valid_o;
  logic [1:0]  resp_hit_o;
  logic        resp_any_taken_o;
  logic [0:0]  resp_taken_lane_o;
  logic [31:0] resp_target_o;
  logic        resp_is_call_o;
  logic        resp_backward_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_taken_i;
  logic        upd_is_call_i;
  logic        flush_i;
  logic        busy_o;

  always #5 clk = ~clk;

  btb_multi_lane dut (
    .clk               (clk),
    .rst               (rst),
    .lookup_valid_i    (lookup_valid_i),
    .lookup_pc_i       (lookup_pc_i),
    .lookup_ready_o    (lookup_ready_o),
    .resp_valid_o      (resp_valid_o),
    .resp_hit_o        (resp_hit_o),
    .resp_any_taken_o  (resp_any_taken_o),
    .resp_taken_lane_o (resp_taken_lane_o),
    .resp_target_o     (resp_target_o),
    .resp_is_call_o    (resp_is_call_o),
    .resp_backward_o   (resp_backward_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_target_i      (upd_target_i),
    .upd_taken_i       (upd_taken_i),
    .upd_is_call_i     (upd_is_call_i),
    .flush_i           (flush_i),
    .busy_o            (busy_o)
  );

  typedef struct {
    int          due;
    logic [1:0]  hit;
    logic        any;
    logic        lane;
    logic [31:0] tgt;
    logic        call;
    logic        back;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks  = 0;
  int n_pass    = 0;
  int cycle_cnt = 0;
  bit mon_en    = 0;
  int sweep_left;

  bit          m_valid [ENTRIES];
  logic [7:0]  m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  bit          m_call  [ENTRIES];
  int          m_ctr   [ENTRIES];

  // Cycle stamp used to check response latency
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
  endtask

  // Invalidation is modelled as instantaneous plus a busy window of ENTRIES cycles
  task automatic startSweep();
    sweep_left = ENTRIES;
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
  endtask

  function automatic exp_t predict(input logic [31:0] base);
    exp_t e;
    bit found;
    e = '{due: cycle_cnt + 1, hit: 2'b00, any: 1'b0, lane: 1'b0, tgt: 32'h0, call: 1'b0, back: 1'b0};
    found = 0;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] pc;
      int idx;
      int tg;
      pc  = base + 32'(4 * k);
      idx = int'((pc >> 2) % 32'(ENTRIES));
      tg  = int'((pc >> 8) % 32'd256);
      if (m_valid[idx] && m_tag[idx] == 8'(tg)) begin
        e.hit[k] = 1'b1;
        if (m_ctr[idx] >= 2 && !found) begin
          found  = 1;
          e.any  = 1'b1;
          e.lane = 1'(k);
          e.tgt  = m_tgt[idx];
          e.call = m_call[idx];
          e.back = (m_tgt[idx] < pc);
        end
      end
    end
    return e;
  endfunction

  task automatic modelUpdate(input logic [31:0] pc, input logic [31:0] tgt, input bit taken, input bit call);
    int idx;
    int tg;
    idx = int'((pc >> 2) % 32'(ENTRIES));
    tg  = int'((pc >> 8) % 32'd256);
    if (m_valid[idx] && m_tag[idx] == 8'(tg)) begin
      if (taken) begin
        if (m_ctr[idx] < 3) m_ctr[idx]++;
        m_tgt[idx]  = tgt;
        m_call[idx] = call;
      end else if (m_ctr[idx] > 0) begin
        m_ctr[idx]--;
      end
    end else if (taken) begin
      m_valid[idx] = 1;
      m_tag[idx]   = 8'(tg);
      m_tgt[idx]   = tgt;
      m_call[idx]  = call;
      m_ctr[idx]   = 2;
    end
  endtask

  // One clock cycle of stimulus: drive, check handshake, advance model, step the clock
  task automatic applyStimulus(input bit do_rst, input bit lv, input logic [31:0] lpc,
                               input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                               input bit utaken, input bit ucall, input bit fl);
    bit exp_idle;
    rst            = do_rst;
    lookup_valid_i = lv;
    lookup_pc_i    = lpc;
    upd_valid_i    = uv;
    upd_pc_i       = upc;
    upd_target_i   = utgt;
    upd_taken_i    = utaken;
    upd_is_call_i  = ucall;
    flush_i        = fl;
    #1;
    if (do_rst) begin
      startSweep();
    end else begin
      exp_idle = (sweep_left == 0);
      checkOutput("busy", 64'(busy_o), 64'(!exp_idle));
      checkOutput("ready", 64'(lookup_ready_o), 64'(exp_idle && !fl));
      if (lv && exp_idle && !fl) sb.push_back(predict(lpc));
      if (uv && exp_idle && !fl) modelUpdate(upc, utgt, utaken, ucall);
      if (fl) startSweep();
      else if (sweep_left > 0) sweep_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    applyStimulus(0, 1, pc, 0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input bit taken, input bit call);
    applyStimulus(0, 0, 32'h0, 1, pc, tgt, taken, call, 0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("rst_resp_valid", 64'(resp_valid_o), 64'(0));
    checkOutput("rst_busy", 64'(busy_o), 64'(1));
    checkOutput("rst_ready", 64'(lookup_ready_o), 64'(0));
  endtask

  function automatic logic [31:0] randPc();
    case ($urandom_range(0, 9))
      0:       return 32'hFFFF_FFFC;
      1:       return 32'h0000_0000;
      default: return 32'h100 + 32'(4 * $urandom_range(0, 191));
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever a response shows up and checks its timing and fields
  always @(negedge clk) begin
    if (mon_en) begin
      if (resp_valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("resp_unexpected", 64'(resp_valid_o), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          checkOutput("resp_cycle", 64'(cycle_cnt), 64'(mon_e.due));
          checkOutput("resp_hit", 64'(resp_hit_o), 64'(mon_e.hit));
          checkOutput("resp_any_taken", 64'(resp_any_taken_o), 64'(mon_e.any));
          checkOutput("resp_taken_lane", 64'(resp_taken_lane_o), 64'(mon_e.lane));
          checkOutput("resp_target", 64'(resp_target_o), 64'(mon_e.tgt));
          checkOutput("resp_is_call", 64'(resp_is_call_o), 64'(mon_e.call));
          checkOutput("resp_backward", 64'(resp_backward_o), 64'(mon_e.back));
        end
      end else begin
        checkOutput("idle_fields", 64'({resp_hit_o, resp_any_taken_o, resp_taken_lane_o,
                                         resp_target_o, resp_is_call_o, resp_backward_o}), 64'(0));
        if (sb.size() > 0 && sb[0].due <= cycle_cnt) begin
          checkOutput("resp_valid", 64'(resp_valid_o), 64'(1));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 8'h0; m_tgt[i] = 32'h0; m_call[i] = 0; m_ctr[i] = 0;
    end
    sweep_left = ENTRIES;

    // Power-on reset, then a full sweep before the first lookup
    doReset();
    mon_en = 1;
    idle(ENTRIES);
    lookup(32'h100);

    // Lane 1 taken branch
    update(32'h104, 32'h140, 1, 0);
    lookup(32'h100);

    // Counter saturation walk and backward target
    update(32'h200, 32'h1E0, 1, 0);
    update(32'h200, 32'h1E0, 0, 0);
    update(32'h200, 32'h1E0, 0, 0);
    lookup(32'h200);
    update(32'h200, 32'h1E0, 1, 1);
    lookup(32'h200);
    update(32'h200, 32'h1E0, 1, 1);
    lookup(32'h200);

    // Aliasing on index 0
    update(32'h100, 32'h180, 1, 1);
    lookup(32'h100);
    update(32'h200, 32'h220, 1, 0);
    lookup(32'h100);
    lookup(32'h200);

    // Lane PC wrap past the top of the address space
    update(32'h0, 32'h80, 1, 0);
    lookup(32'hFFFF_FFFC);

    // Same-cycle lookup and update to the same entry
    applyStimulus(0, 1, 32'h300, 1, 32'h300, 32'h10, 1, 0, 0);
    lookup(32'h300);

    // Flush with a pending response, traffic during the sweep, restart mid-sweep
    lookup(32'h100);
    applyStimulus(0, 1, 32'h104, 1, 32'h400, 32'h500, 1, 0, 1);
    for (int i = 0; i < 30; i++) applyStimulus(0, 1, 32'h100, 1, 32'h104, 32'h600, 1, 0, 0);
    applyStimulus(0, 1, 32'h100, 1, 32'h104, 32'h600, 1, 0, 1);
    for (int i = 0; i < ENTRIES; i++) applyStimulus(0, 1, 32'h200, 1, 32'h200, 32'h700, 1, 1, 0);
    lookup(32'h100);
    lookup(32'h200);
    lookup(32'h300);
    lookup(32'hFFFF_FFFC);

    // Random traffic with occasional flushes
    for (int i = 0; i < 2500; i++) begin
      applyStimulus(0, ($urandom_range(0, 9) < 7), randPc(),
                    ($urandom_range(0, 1) == 1), randPc(), $urandom(),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 79) == 0));
    end

    // Reset in the same cycle as a lookup discards its response
    idle(ENTRIES);
    update(32'h104, 32'h140, 1, 0);
    applyStimulus(1, 1, 32'h100, 0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
    idle(ENTRIES);
    lookup(32'h100);
    for (int i = 0; i < 500; i++) begin
      applyStimulus(0, ($urandom_range(0, 9) < 7), randPc(),
                    ($urandom_range(0, 1) == 1), randPc(), $urandom(),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 0);
    end

    idle(3);
    checkOutput("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
